fuzzy_cut_aggregator: RTL and testbench

- Sequential successor to the two-operand cut-line merger.
- Accepts a stream of rule-output membership vectors, one vector per beat, over a valid/ready handshake.
- Folds all beats of a frame into one accumulated vector, using a run-time selectable merge mode and a per-beat cut line.
- Defuzzifies the result with a bit-serial count/centroid engine. Sits between the rule-evaluation stage and the controller output stage.

---
 rtl/fuzzy_cut_aggregator.sv | 238 +++++++++++++++++++++++
 tb/tb_fuzzy_cut_aggregator.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fuzzy_cut_aggregator.sv
// Frame-level fuzzy membership aggregator: folds rule vectors beat by beat with a
// selectable cut-line merge, then defuzzifies (popcount + centroid) bit-serially.
module fuzzy_cut_aggregator #(
    parameter int unsigned WIDTH     = 10,
    parameter int unsigned MAX_BEATS = 4,
    parameter int unsigned CW        = $clog2(WIDTH + 1),
    parameter int unsigned SW        = $clog2(WIDTH * (WIDTH - 1) / 2 + 1),
    parameter int unsigned IW        = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       cfg_mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    input  logic [WIDTH-1:0] in_vec,
    input  logic [WIDTH-1:0] in_cut,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_vec,
    output logic [CW-1:0]    out_count,
    output logic [IW-1:0]    out_centroid,
    output logic             out_empty,
    output logic             out_trunc,
    output logic             busy
);

    localparam int unsigned BW   = $clog2(MAX_BEATS + 1);
    localparam int unsigned NMAX = (WIDTH > SW) ? WIDTH : SW;
    localparam int unsigned KW   = $clog2(NMAX + 1);
    localparam logic [1:0] MODE_CUT  = 2'd1;
    localparam logic [1:0] MODE_BOTH = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCUM,
        S_DEFUZZ,
        S_DIV,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [1:0]       mode_q, mode_d;
    logic [BW-1:0]    beats_q, beats_d;
    logic             trunc_q, trunc_d;
    logic [KW-1:0]    step_q, step_d;
    logic [CW-1:0]    count_q, count_d;
    logic [SW-1:0]    wsum_q, wsum_d;
    logic [CW-1:0]    rem_q, rem_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_vec_q, out_vec_d;
    logic [CW-1:0]    out_count_q, out_count_d;
    logic [IW-1:0]    out_centroid_q, out_centroid_d;
    logic             out_empty_q, out_empty_d;
    logic             out_trunc_q, out_trunc_d;

    logic             accept_c;
    logic [BW-1:0]    beat_next_c;
    logic             close_c;
    logic [WIDTH-1:0] acc_shift_c;
    logic             scan_bit_c;
    logic [CW:0]      rem_sh_c;
    logic             qbit_c;

    // Per-bit merge of the running accumulator a with the incoming vector b.
    function automatic logic [WIDTH-1:0] merge_vec(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [WIDTH-1:0] cut,
        input logic [1:0]       mode
    );
        logic [WIDTH-1:0] lo;
        logic [WIDTH-1:0] hi;
        logic [WIDTH-1:0] look;
        logic [WIDTH-1:0] res;
        logic [WIDTH+1:0] lo_p;
        logic [WIDTH+1:0] hi_p;
        lo   = (a < b) ? a : b;
        hi   = (a < b) ? b : a;
        lo_p = {1'b0, lo, 1'b0};
        hi_p = {1'b0, hi, 1'b0};
        look = '0;
        // Zero-padded copies make the edge bits read absent neighbours as 0.
        for (int i = 0; i < WIDTH; i++) begin
            look[i] = lo_p[i+1] | (hi_p[i+2] & hi_p[i+1] & hi_p[i] & lo_p[i]);
        end
        case (mode)
            MODE_CUT:  res = (cut & (a | b)) | (~cut & (a & b));
            MODE_BOTH: res = (cut & (a | b)) | (~cut & look);
            default:   res = a | b;
        endcase
        return res;
    endfunction

    assign accept_c    = in_valid && in_ready_q;
    assign beat_next_c = (state_q == S_IDLE) ? BW'(1) : beats_q + BW'(1);
    assign close_c     = in_last || (beat_next_c == BW'(MAX_BEATS));
    assign acc_shift_c = acc_q >> step_q;
    assign scan_bit_c  = acc_shift_c[0];

    // One restoring-division step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        rem_sh_c = {rem_q, wsum_q[SW-1]};
        qbit_c   = (rem_sh_c >= {1'b0, count_q});
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d        = state_q;
        acc_d          = acc_q;
        mode_d         = mode_q;
        beats_d        = beats_q;
        trunc_d        = trunc_q;
        step_d         = step_q;
        count_d        = count_q;
        wsum_d         = wsum_q;
        rem_d          = rem_q;
        out_valid_d    = out_valid_q;
        out_vec_d      = out_vec_q;
        out_count_d    = out_count_q;
        out_centroid_d = out_centroid_q;
        out_empty_d    = out_empty_q;
        out_trunc_d    = out_trunc_q;

        case (state_q)
            S_IDLE, S_ACCUM: begin
                if (accept_c) begin
                    if (state_q == S_IDLE) begin
                        acc_d  = in_vec;
                        mode_d = cfg_mode;
                    end else begin
                        acc_d = merge_vec(acc_q, in_vec, in_cut, mode_q);
                    end
                    beats_d = beat_next_c;
                    if (close_c) begin
                        state_d = S_DEFUZZ;
                        trunc_d = !in_last;
                        step_d  = '0;
                        count_d = '0;
                        wsum_d  = '0;
                        rem_d   = '0;
                    end else begin
                        state_d = S_ACCUM;
                    end
                end
            end
            S_DEFUZZ: begin
                count_d = count_q + CW'(scan_bit_c);
                wsum_d  = wsum_q + (scan_bit_c ? SW'(step_q) : SW'(0));
                if (step_q == KW'(WIDTH - 1)) begin
                    state_d = S_DIV;
                    step_d  = '0;
                end else begin
                    step_d = step_q + KW'(1);
                end
            end
            S_DIV: begin
                if (step_q < KW'(SW)) begin
                    rem_d  = qbit_c ? CW'(rem_sh_c - {1'b0, count_q}) : CW'(rem_sh_c);
                    wsum_d = {wsum_q[SW-2:0], qbit_c};
                    step_d = step_q + KW'(1);
                end else begin
                    // wsum now holds the quotient; publish the frame result.
                    state_d        = S_DONE;
                    out_valid_d    = 1'b1;
                    out_vec_d      = acc_q;
                    out_count_d    = count_q;
                    out_centroid_d = (count_q == '0) ? IW'(0) : wsum_q[IW-1:0];
                    out_empty_d    = (count_q == '0);
                    out_trunc_d    = trunc_q;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        in_ready_d = (state_d == S_IDLE) || (state_d == S_ACCUM);
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            acc_q          <= '0;
            mode_q         <= '0;
            beats_q        <= '0;
            trunc_q        <= 1'b0;
            step_q         <= '0;
            count_q        <= '0;
            wsum_q         <= '0;
            rem_q          <= '0;
            in_ready_q     <= 1'b0;
            busy_q         <= 1'b0;
            out_valid_q    <= 1'b0;
            out_vec_q      <= '0;
            out_count_q    <= '0;
            out_centroid_q <= '0;
            out_empty_q    <= 1'b0;
            out_trunc_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            acc_q          <= acc_d;
            mode_q         <= mode_d;
            beats_q        <= beats_d;
            trunc_q        <= trunc_d;
            step_q         <= step_d;
            count_q        <= count_d;
            wsum_q         <= wsum_d;
            rem_q          <= rem_d;
            in_ready_q     <= in_ready_d;
            busy_q         <= busy_d;
            out_valid_q    <= out_valid_d;
            out_vec_q      <= out_vec_d;
            out_count_q    <= out_count_d;
            out_centroid_q <= out_centroid_d;
            out_empty_q    <= out_empty_d;
            out_trunc_q    <= out_trunc_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign busy         = busy_q;
    assign out_valid    = out_valid_q;
    assign out_vec      = out_vec_q;
    assign out_count    = out_count_q;
    assign out_centroid = out_centroid_q;
    assign out_empty    = out_empty_q;
    assign out_trunc    = out_trunc_q;

endmodule

// File: tb/tb_fuzzy_cut_aggregator.sv
// Bench for fuzzy_cut_aggregator: directed frames from the test plan plus random
// frames compared against a behavioural merge/centroid model.
module tb_fuzzy_cut_aggregator;

    localparam int unsigned W   = 10;
    localparam int unsigned MB  = 4;
    localparam int unsigned CW  = $clog2(W + 1);
    localparam int unsigned SW  = $clog2(W * (W - 1) / 2 + 1);
    localparam int unsigned IW  = $clog2(W);
    localparam int          LAT = W + SW + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    cfg_mode = 2'd0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_last = 1'b0;
    logic [W-1:0]  in_vec = '0;
    logic [W-1:0]  in_cut = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_vec;
    logic [CW-1:0] out_count;
    logic [IW-1:0] out_centroid;
    logic          out_empty;
    logic          out_trunc;
    logic          busy;

    fuzzy_cut_aggregator #(.WIDTH(W), .MAX_BEATS(MB)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_mode(cfg_mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .in_vec(in_vec), .in_cut(in_cut),
        .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec),
        .out_count(out_count), .out_centroid(out_centroid),
        .out_empty(out_empty), .out_trunc(out_trunc), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int accept_cyc = 0;
    logic [W-1:0] fv[$];
    logic [W-1:0] fc[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic bit_at(input logic [W-1:0] v, input int j);
        logic [W-1:0] t;
        if (j < 0 || j >= int'(W)) return 1'b0;
        t = v >> j;
        return t[0];
    endfunction

    // Reference merge written straight from the per-bit rule.
    function automatic logic [W-1:0] ref_merge(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic [W-1:0] c, input logic [1:0] mode);
        logic [W-1:0] z;
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic zi;
        if (a < b) begin lo = a; hi = b; end
        else begin lo = b; hi = a; end
        z = '0;
        for (int i = 0; i < int'(W); i++) begin
            if (bit_at(c, i) || mode == 2'd0 || mode == 2'd3)
                zi = bit_at(a, i) | bit_at(b, i);
            else if (mode == 2'd1)
                zi = bit_at(a, i) & bit_at(b, i);
            else
                zi = bit_at(lo, i) | (bit_at(hi, i + 1) & bit_at(hi, i) & bit_at(hi, i - 1)
                                      & bit_at(lo, i - 1));
            z = z | (W'(zi) << i);
        end
        return z;
    endfunction

    task automatic model(input logic [1:0] mode, output logic [W-1:0] ev,
                         output int ecnt, output int ecen);
        int sum;
        ev = fv[0];
        for (int j = 1; j < fv.size(); j++) ev = ref_merge(ev, fv[j], fc[j], mode);
        ecnt = 0;
        sum  = 0;
        for (int i = 0; i < int'(W); i++) begin
            if (bit_at(ev, i)) begin ecnt++; sum += i; end
        end
        ecen = (ecnt == 0) ? 0 : sum / ecnt;
    endtask

    // Called just after a negedge; returns just after the negedge following acceptance.
    task automatic send_beat(input logic [W-1:0] v, input logic [W-1:0] c, input logic l);
        int n = 0;
        in_valid = 1'b1; in_vec = v; in_cut = c; in_last = l;
        while (in_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        chk("beat_accept_timeout", 32'(n < 200), 32'd1);
        @(posedge clk);
        @(negedge clk);
        accept_cyc = cyc;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic drive_frame(input logic [1:0] mode, input logic trunc);
        for (int j = 0; j < fv.size(); j++) begin
            cfg_mode = (j == 0) ? mode : 2'($urandom_range(0, 3));
            send_beat(fv[j], fc[j], (j == fv.size() - 1) && !trunc);
        end
    endtask

    task automatic get_result(input string tag, input logic [W-1:0] ev, input int ecnt,
                              input int ecen, input logic etr, input int stall);
        int n = 0;
        logic rdy_low = 1'b1;
        logic stable = 1'b1;
        out_ready = 1'b0;
        while (out_valid !== 1'b1 && n < 200) begin
            if (in_ready !== 1'b0) rdy_low = 1'b0;
            @(negedge clk); n++;
        end
        chk($sformatf("%s_latency", tag), 32'(cyc - accept_cyc), 32'(LAT));
        chk($sformatf("%s_rdy_low", tag), 32'(rdy_low), 32'd1);
        chk($sformatf("%s_vec", tag), 32'(out_vec), 32'(ev));
        chk($sformatf("%s_count", tag), 32'(out_count), 32'(ecnt));
        chk($sformatf("%s_centroid", tag), 32'(out_centroid), 32'(ecen));
        chk($sformatf("%s_empty", tag), 32'(out_empty), 32'(ecnt == 0));
        chk($sformatf("%s_trunc", tag), 32'(out_trunc), 32'(etr));
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_vec !== ev ||
                out_count !== CW'(ecnt) || out_centroid !== IW'(ecen) ||
                out_trunc !== etr || busy !== 1'b1) stable = 1'b0;
        end
        chk($sformatf("%s_stall_stable", tag), 32'(stable), 32'd1);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk($sformatf("%s_post_valid", tag), 32'(out_valid), 32'd0);
        chk($sformatf("%s_post_idle", tag), 32'({busy, in_ready}), 32'b01);
        chk($sformatf("%s_post_hold", tag), 32'(out_vec), 32'(ev));
    endtask

    initial begin
        logic [W-1:0] ev;
        int ecnt;
        int ecen;
        logic [1:0] mode;
        logic trunc;
        int nb;

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outs", 32'({out_valid, in_ready, busy, out_empty, out_trunc}), 32'd0);
        chk("reset_vec", 32'(out_vec), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_ready", 32'(in_ready), 32'd1);

        // Mode 0 union
        fv = '{10'h00F, 10'h0F0}; fc = '{10'h000, 10'h000};
        drive_frame(2'd0, 1'b0);
        get_result("union", 10'h0FF, 8, 3, 1'b0, 1);

        // Mode 2 bothlook, uncut and fully cut
        fv = '{10'h00E, 10'h03C}; fc = '{10'h000, 10'h000};
        drive_frame(2'd2, 1'b0);
        get_result("both_nocut", 10'h01E, 4, 2, 1'b0, 0);
        fv = '{10'h00E, 10'h03C}; fc = '{10'h000, 10'h3FF};
        drive_frame(2'd2, 1'b0);
        get_result("both_cut", 10'h03E, 5, 3, 1'b0, 2);

        // Mode 1 cut-intersect, including an empty result
        fv = '{10'h0FF, 10'h00C}; fc = '{10'h000, 10'h00F};
        drive_frame(2'd1, 1'b0);
        get_result("cutint", 10'h00F, 4, 1, 1'b0, 0);
        fv = '{10'h00F, 10'h0F0}; fc = '{10'h000, 10'h000};
        drive_frame(2'd1, 1'b0);
        get_result("empty", 10'h000, 0, 0, 1'b0, 20);

        // Truncation at MAX_BEATS with the fifth beat held valid through DONE
        fv = '{10'h001, 10'h002, 10'h004, 10'h008}; fc = '{10'h0, 10'h0, 10'h0, 10'h0};
        drive_frame(2'd0, 1'b1);
        cfg_mode = 2'd0; in_valid = 1'b1; in_vec = 10'h200; in_cut = '0; in_last = 1'b1;
        get_result("trunc", 10'h00F, 4, 1, 1'b1, 3);
        send_beat(10'h200, 10'h000, 1'b1);
        get_result("frame2", 10'h200, 1, 9, 1'b0, 0);

        // Reset mid-DEFUZZ discards the frame
        cfg_mode = 2'd0;
        send_beat(10'h0F0, 10'h000, 1'b1);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midreset_outs", 32'({out_valid, in_ready, busy}), 32'd0);
        chk("midreset_vec", 32'(out_vec), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midreset_ready", 32'({busy, in_ready}), 32'b01);
        send_beat(10'h300, 10'h000, 1'b1);
        get_result("after_reset", 10'h300, 2, 8, 1'b0, 0);

        // Random frames against the reference model
        for (int f = 0; f < 40; f++) begin
            mode  = 2'($urandom_range(0, 3));
            nb    = $urandom_range(1, MB);
            trunc = (nb == int'(MB)) && ($urandom_range(0, 1) == 1);
            fv = {}; fc = {};
            for (int j = 0; j < nb; j++) begin
                case ($urandom_range(0, 2))
                    0:       fv.push_back(W'($urandom) & W'($urandom));
                    1:       fv.push_back(W'($urandom) | W'($urandom));
                    default: fv.push_back(W'($urandom));
                endcase
                case ($urandom_range(0, 3))
                    0:       fc.push_back('0);
                    1:       fc.push_back('1);
                    default: fc.push_back(W'($urandom));
                endcase
            end
            model(mode, ev, ecnt, ecen);
            drive_frame(mode, trunc);
            get_result($sformatf("rand%0d", f), ev, ecnt, ecen, trunc, $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
